// File: rtl/bsg_manycore_trace_pkg.sv
// rtl/bsg_manycore_trace_pkg.sv - trace record type, marker code and capture states
`ifndef BSG_MANYCORE_TRACE_PKG_SV
`define BSG_MANYCORE_TRACE_PKG_SV

// Record layout, MSB to LSB: {x, y, pc, rd, data, exc}
`define DECLARE_BSG_MANYCORE_TRACE_RECORD_S(x_cord_width_mp, y_cord_width_mp) \
  typedef struct packed { \
    logic [(x_cord_width_mp)-1:0] x; \
    logic [(y_cord_width_mp)-1:0] y; \
    logic [31:0] pc; \
    logic [4:0]  rd; \
    logic [31:0] data; \
    logic [3:0]  exc; \
  } bsg_manycore_trace_record_s

package bsg_manycore_trace_pkg;

  // Exception code reserved for "events were lost here" marker records
  localparam logic [3:0] trace_marker_exc_gp = 4'hF;

  // NORMAL captures events; LOST counts dropped events until a marker fits
  typedef enum logic {
    e_trace_normal = 1'b0,
    e_trace_lost   = 1'b1
  } trace_state_e;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`endif

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - one-write one-read register file with unsynchronized read
module bsg_mem_1r1w #(
  parameter int width_p      = 8,
  parameter int els_p        = 8,
  parameter int addr_width_p = (els_p > 1) ? $clog2(els_p) : 1
)(
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Write port; contents are not reset since readers are gated by occupancy
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_manycore_vscale_wb_trace_buffer.sv
// rtl/bsg_manycore_vscale_wb_trace_buffer.sv - FIFO of writeback trace records with loss markers
module bsg_manycore_vscale_wb_trace_buffer
  import bsg_manycore_trace_pkg::*;
#(
  parameter x_cord_width_p = "inv",
  parameter y_cord_width_p = "inv",
  parameter int els_p      = 8
)(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   freeze_i,
  input  logic [x_cord_width_p-1:0]              my_x_i,
  input  logic [y_cord_width_p-1:0]              my_y_i,
  input  logic [31:0]                            pc_wb_i,
  input  logic                                   wr_reg_wb_i,
  input  logic [4:0]                             reg_to_wr_wb_i,
  input  logic [31:0]                            wb_data_wb_i,
  input  logic                                   stall_wb_i,
  input  logic [3:0]                             exception_code_wb_i,
  output logic                                   v_o,
  output logic [x_cord_width_p+y_cord_width_p+72:0] data_o,
  input  logic                                   yumi_i,
  output logic [$clog2(els_p+1)-1:0]             count_o,
  output logic [15:0]                            drop_count_o
);

  localparam int lg_els_lp       = $clog2(els_p);
  localparam int count_width_lp  = $clog2(els_p+1);
  localparam int record_width_lp = x_cord_width_p + y_cord_width_p + 73;

  `DECLARE_BSG_MANYCORE_TRACE_RECORD_S(x_cord_width_p, y_cord_width_p);

  trace_state_e               state_r;
  logic [lg_els_lp-1:0]       wptr_r, rptr_r;
  logic [count_width_lp-1:0]  count_r;
  logic [15:0]                lost_cnt_r, drop_count_r;

  logic                       event_v, deq, free_v, enq, drop, use_marker;
  logic [15:0]                lost_cnt_bump;
  bsg_manycore_trace_record_s event_rec, marker_rec, enq_rec;
  logic [record_width_lp-1:0] head_data;

  assign event_v = ~freeze_i & ~stall_wb_i
                 & ((wr_reg_wb_i & (reg_to_wr_wb_i != 5'd0)) | (exception_code_wb_i != 4'd0));

  assign v_o    = (count_r != '0);
  assign deq    = yumi_i & v_o;
  // A pop in the same cycle frees the slot the push will occupy
  assign free_v = (count_r < count_width_lp'(els_p)) | deq;

  // Lost count as it stands after this cycle's event, so a marker includes it
  assign lost_cnt_bump = event_v ? sat_inc16(lost_cnt_r) : lost_cnt_r;

  // Record builders for a captured event and for a loss marker
  always_comb begin
    event_rec      = '0;
    event_rec.x    = my_x_i;
    event_rec.y    = my_y_i;
    event_rec.pc   = pc_wb_i;
    event_rec.rd   = reg_to_wr_wb_i;
    event_rec.data = wb_data_wb_i;
    event_rec.exc  = exception_code_wb_i;

    marker_rec      = '0;
    marker_rec.x    = my_x_i;
    marker_rec.y    = my_y_i;
    marker_rec.data = {16'd0, lost_cnt_bump};
    marker_rec.exc  = trace_marker_exc_gp;
  end

  // Decide per cycle whether to push, and what; in LOST the marker wins over any event
  always_comb begin
    enq        = 1'b0;
    drop       = 1'b0;
    use_marker = 1'b0;
    case (state_r)
      e_trace_normal: begin
        enq  = event_v & free_v;
        drop = event_v & ~free_v;
      end
      e_trace_lost: begin
        drop       = event_v;
        enq        = free_v;
        use_marker = free_v;
      end
      default: begin
        enq = 1'b0;
      end
    endcase
  end

  assign enq_rec = use_marker ? marker_rec : event_rec;

  bsg_mem_1r1w #(
    .width_p      (record_width_lp),
    .els_p        (els_p),
    .addr_width_p (lg_els_lp)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_r),
    .w_data_i (enq_rec),
    .r_addr_i (rptr_r),
    .r_data_o (head_data)
  );

  assign data_o       = head_data;
  assign count_o      = count_r;
  assign drop_count_o = drop_count_r;

  // Pointers, occupancy, drop accounting and the NORMAL/LOST state machine
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= e_trace_normal;
      wptr_r       <= '0;
      rptr_r       <= '0;
      count_r      <= '0;
      lost_cnt_r   <= '0;
      drop_count_r <= '0;
    end else begin
      // Power-of-two depth makes natural overflow the modulo wrap
      if (enq) wptr_r <= wptr_r + lg_els_lp'(1);
      if (deq) rptr_r <= rptr_r + lg_els_lp'(1);

      case ({enq, deq})
        2'b10:   count_r <= count_r + count_width_lp'(1);
        2'b01:   count_r <= count_r - count_width_lp'(1);
        default: count_r <= count_r;
      endcase

      if (drop) drop_count_r <= sat_inc16(drop_count_r);

      case (state_r)
        e_trace_normal: begin
          if (drop) begin
            state_r    <= e_trace_lost;
            lost_cnt_r <= 16'd1;
          end
        end
        e_trace_lost: begin
          if (free_v) begin
            state_r    <= e_trace_normal;
            lost_cnt_r <= 16'd0;
          end else begin
            lost_cnt_r <= lost_cnt_bump;
          end
        end
        default: begin
          state_r <= e_trace_normal;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_vscale_wb_trace_buffer.sv
// tb/tb_bsg_manycore_vscale_wb_trace_buffer.sv - self-checking bench for the writeback trace buffer
module tb_bsg_manycore_vscale_wb_trace_buffer;

  localparam int X_W = 3;
  localparam int Y_W = 2;
  localparam int ELS = 4;
  localparam int RW  = X_W + Y_W + 73;
  localparam int CW  = $clog2(ELS + 1);

  logic           clk;
  logic           reset_i, freeze_i, wr_reg, stall, yumi;
  logic [X_W-1:0] my_x;
  logic [Y_W-1:0] my_y;
  logic [31:0]    pc, wdata;
  logic [4:0]     rd;
  logic [3:0]     exc;
  logic           v_o;
  logic [RW-1:0]  data_o;
  logic [CW-1:0]  count_o;
  logic [15:0]    drop_count_o;

  int checks = 0;
  int errors = 0;

  // Reference model: record queue, loss mode flag, pending lost count, total drops
  logic [RW-1:0] q[$];
  bit            m_lost;
  int            m_lostcnt;
  int            m_drop;

  bsg_manycore_vscale_wb_trace_buffer #(
    .x_cord_width_p (X_W),
    .y_cord_width_p (Y_W),
    .els_p          (ELS)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .freeze_i            (freeze_i),
    .my_x_i              (my_x),
    .my_y_i              (my_y),
    .pc_wb_i             (pc),
    .wr_reg_wb_i         (wr_reg),
    .reg_to_wr_wb_i      (rd),
    .wb_data_wb_i        (wdata),
    .stall_wb_i          (stall),
    .exception_code_wb_i (exc),
    .v_o                 (v_o),
    .data_o              (data_o),
    .yumi_i              (yumi),
    .count_o             (count_o),
    .drop_count_o        (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mk(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                       input logic [31:0] p, input logic [4:0] r,
                                       input logic [31:0] d, input logic [3:0] e);
    return {x, y, p, r, d, e};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("v_o", v_o, (q.size() != 0));
    check("count_o", count_o, q.size());
    check("drop_count_o", drop_count_o, m_drop);
    if (q.size() != 0) check("data_o", data_o, q[0]);
  endtask

  task automatic set_in(input bit fz, input bit st, input bit wr, input logic [4:0] r,
                        input logic [31:0] p, input logic [31:0] d, input logic [3:0] e,
                        input bit y);
    freeze_i = fz; stall = st; wr_reg = wr; rd = r; pc = p; wdata = d; exc = e; yumi = y;
  endtask

  // One clock: predict from the rules, advance, then compare away from the edge
  task automatic do_cycle(input bit chk);
    bit ev, dq, fr;
    ev = !freeze_i && !stall && ((wr_reg && rd != 0) || exc != 0);
    dq = yumi && (q.size() != 0);
    fr = (q.size() < ELS) || dq;
    @(posedge clk);
    if (dq) void'(q.pop_front());
    if (!m_lost) begin
      if (ev && fr) q.push_back(mk(my_x, my_y, pc, rd, wdata, exc));
      else if (ev) begin
        m_drop    = (m_drop < 65535) ? m_drop + 1 : 65535;
        m_lostcnt = 1;
        m_lost    = 1'b1;
      end
    end else begin
      if (ev) begin
        m_drop    = (m_drop < 65535) ? m_drop + 1 : 65535;
        m_lostcnt = (m_lostcnt < 65535) ? m_lostcnt + 1 : 65535;
      end
      if (fr) begin
        q.push_back(mk(my_x, my_y, 32'd0, 5'd0, {16'd0, m_lostcnt[15:0]}, 4'hF));
        m_lostcnt = 0;
        m_lost    = 1'b0;
      end
    end
    #1;
    if (chk) check_state();
  endtask

  task automatic ev_cycle(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d,
                          input bit y);
    set_in(0, 0, 1, r, p, d, 4'd0, y);
    do_cycle(1);
  endtask

  task automatic idle_cycle(input bit y);
    set_in(0, 0, 0, 5'd0, 32'd0, 32'd0, 4'd0, y);
    do_cycle(1);
  endtask

  initial begin
    m_lost = 0; m_lostcnt = 0; m_drop = 0;
    my_x = 3'd5; my_y = 2'd2;
    set_in(0, 0, 0, 5'd0, 32'd0, 32'd0, 4'd0, 0);
    reset_i = 1'b0;
    #1 reset_i = 1'b1;
    #5;
    check("reset_v_o", v_o, 1'b0);
    check("reset_count", count_o, 0);
    check("reset_drop", drop_count_o, 0);
    #1 reset_i = 1'b0;

    // Single event appears after one edge with every field intact
    ev_cycle(32'h100, 5'd5, 32'hDEAD_BEEF, 0);
    check("ev_v_o", v_o, 1'b1);
    check("ev_count", count_o, 1);
    check("ev_rd_field", data_o[40:36], 5'd5);
    check("ev_data_field", data_o[35:4], 32'hDEAD_BEEF);
    check("ev_pc_field", data_o[72:41], 32'h100);
    check("ev_xy_field", data_o[77:73], {3'd5, 2'd2});
    idle_cycle(1);

    // Non-events: rd=0 write, stalled, frozen; yumi on empty is ignored
    set_in(0, 0, 1, 5'd0, 32'h200, 32'h1, 4'd0, 1); do_cycle(1);
    set_in(0, 1, 1, 5'd3, 32'h204, 32'h2, 4'd0, 0); do_cycle(1);
    set_in(1, 0, 1, 5'd3, 32'h208, 32'h3, 4'd2, 0); do_cycle(1);
    check("nonevent_count", count_o, 0);
    check("nonevent_drop", drop_count_o, 0);

    // Overflow into LOST, then a single pop admits a marker behind the survivors
    for (int i = 0; i < 6; i++) ev_cycle(32'h300 + 4 * i, 5'd1 + 5'(i), 32'hA0 + i, 0);
    check("ovf_count", count_o, 4);
    check("ovf_drop", drop_count_o, 2);
    idle_cycle(1);
    for (int i = 0; i < 3; i++) idle_cycle(1);
    check("marker_exc", data_o[3:0], 4'hF);
    check("marker_data", data_o[35:4], 32'd2);
    idle_cycle(1);

    // Full buffer with same-cycle pop and event: accepted, no drop
    for (int i = 0; i < 4; i++) ev_cycle(32'h400 + 4 * i, 5'd7, 32'hB0 + i, 0);
    ev_cycle(32'h500, 5'd9, 32'hC0, 1);
    check("full_swap_count", count_o, 4);
    check("full_swap_drop", drop_count_o, 2);
    // One more drop, then a frozen cycle still drains and emits the marker
    ev_cycle(32'h504, 5'd9, 32'hC1, 0);
    set_in(1, 0, 1, 5'd4, 32'h508, 32'hC2, 4'd3, 1); do_cycle(1);
    for (int i = 0; i < 4; i++) idle_cycle(1);

    // Randomized traffic with two drain rates
    for (int i = 0; i < 400; i++) begin
      my_x = 3'($urandom); my_y = 2'($urandom);
      set_in(($urandom % 8) == 0, ($urandom % 6) == 0, $urandom % 2,
             (($urandom % 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, $urandom,
             (($urandom % 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
             (i < 200) ? (($urandom % 4) == 0) : (($urandom % 10) < 7));
      do_cycle(1);
    end
    for (int i = 0; i < 6; i++) idle_cycle(1);

    // Saturation of both drop counters
    for (int i = 0; i < 4; i++) ev_cycle(32'h600 + 4 * i, 5'd2, 32'hD0 + i, 0);
    set_in(0, 0, 0, 5'd0, 32'h700, 32'h0, 4'd1, 0);
    for (int i = 0; i < 70000; i++) do_cycle(0);
    check_state();
    check("sat_drop", drop_count_o, 16'hFFFF);
    idle_cycle(1);
    for (int i = 0; i < 3; i++) idle_cycle(1);
    check("sat_marker_data", data_o[35:4], 32'h0000_FFFF);
    check("sat_marker_exc", data_o[3:0], 4'hF);
    idle_cycle(1);

    // Asynchronous reset between edges with records buffered
    for (int i = 0; i < 3; i++) ev_cycle(32'h800 + 4 * i, 5'd3, 32'hE0 + i, 0);
    check("pre_reset_count", count_o, 3);
    reset_i = 1'b1;
    #2;
    check("async_v_o", v_o, 1'b0);
    check("async_count", count_o, 0);
    check("async_drop", drop_count_o, 0);
    reset_i = 1'b0;
    q.delete(); m_lost = 0; m_lostcnt = 0; m_drop = 0;
    ev_cycle(32'h900, 5'd11, 32'h1234_5678, 0);
    check("post_reset_count", count_o, 1);
    check("post_reset_pc", data_o[72:41], 32'h900);
    idle_cycle(1);
    check("post_reset_empty", v_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
